// File: rtl/cpkt_unf_mc.sv
// cpkt_unf_mc: SOC/EOC cell-to-packet unframer with valid/ready output and error pulses.
// Define CPKT_UNF_MC_STAT_EN to add saturating stat_pkt/stat_err counters.
module cpkt_unf_mc #(
  parameter int DWID     = 256,
  parameter int FCMWID   = 50,
  parameter int EOC_MSB  = 2,
  parameter int EOC_LSB  = 2,
  parameter int SOC_MSB  = 3,
  parameter int SOC_LSB  = 3,
  parameter int MAX_CELL = 8,
  parameter int CNT_WID  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cell_vld,
  input  logic [DWID-1:0]          cell_dat,
  input  logic [FCMWID-1:0]        cell_msg,
  output logic                     cpkt_vld,
  input  logic                     cpkt_rdy,
  output logic [DWID*MAX_CELL-1:0] cpkt_dat,
  output logic [FCMWID-1:0]        cpkt_msg,
  output logic [CNT_WID-1:0]       cpkt_ncell,
`ifdef CPKT_UNF_MC_STAT_EN
  output logic [31:0]              stat_pkt,
  output logic [31:0]              stat_err,
`endif
  output logic [3:0]               err_pls
);
  localparam int PW = DWID*MAX_CELL;
  typedef enum logic [1:0] {IDLE, ASM, DROP} st_t;
  st_t st, st_n;
  logic [CNT_WID-1:0] cnt, cnt_n;
  logic [PW-1:0] pbuf, pbuf_n;
  logic [2:0] err_n;
  logic cmp, blk, soc, eoc;
  assign soc = |cell_msg[SOC_MSB:SOC_LSB];
  assign eoc = |cell_msg[EOC_MSB:EOC_LSB];
  assign blk = cpkt_vld & ~cpkt_rdy;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    pbuf_n = pbuf;
    cmp = 1'b0;
    err_n = '0;
    if (cell_vld) begin
      if (soc) begin
        pbuf_n = {cell_dat, {(PW-DWID){1'b0}}};
        cnt_n = CNT_WID'(1);
        err_n[1] = st == ASM;
        cmp = eoc;
        st_n = eoc ? IDLE : ASM;
      end else if (st == ASM) begin
        pbuf_n[DWID*(MAX_CELL-1-int'(cnt)) +: DWID] = cell_dat;
        cnt_n = cnt + 1'b1;
        cmp = eoc;
        err_n[2] = !eoc && cnt_n == CNT_WID'(MAX_CELL);
        st_n = eoc ? IDLE : (err_n[2] ? DROP : ASM);
      end else begin
        err_n[0] = st == IDLE;
        st_n = eoc ? IDLE : st;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      pbuf <= '0;
      cpkt_vld <= 1'b0;
      cpkt_dat <= '0;
      cpkt_msg <= '0;
      cpkt_ncell <= '0;
      err_pls <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      pbuf <= pbuf_n;
      err_pls <= {cmp & blk, err_n};
      if (cmp && !blk) begin
        cpkt_vld <= 1'b1;
        cpkt_dat <= pbuf_n;
        cpkt_msg <= cell_msg;
        cpkt_ncell <= cnt_n;
      end else if (cpkt_rdy) begin
        cpkt_vld <= 1'b0;
      end
    end
  end
`ifdef CPKT_UNF_MC_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt <= '0;
      stat_err <= '0;
    end else begin
      if (cpkt_vld && cpkt_rdy && ~&stat_pkt) stat_pkt <= stat_pkt + 1'b1;
      if (|err_pls && ~&stat_err) stat_err <= stat_err + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cpkt_unf_mc.sv
// tb_cpkt_unf_mc: directed and random cells checked against a queue-based packet model.
module tb_cpkt_unf_mc;
  localparam int DW = 256, MW = 50, MC = 8;
  logic clk = 1'b0, rst = 1'b1, cell_vld = 1'b0, cpkt_rdy = 1'b1;
  logic [DW-1:0] cell_dat = '0;
  logic [MW-1:0] cell_msg = '0;
  logic cpkt_vld;
  logic [DW*MC-1:0] cpkt_dat;
  logic [MW-1:0] cpkt_msg;
  logic [3:0] cpkt_ncell, err_pls;
`ifdef CPKT_UNF_MC_STAT_EN
  logic [31:0] stat_pkt, stat_err;
`endif
  cpkt_unf_mc dut (
    .clk(clk), .rst(rst), .cell_vld(cell_vld), .cell_dat(cell_dat), .cell_msg(cell_msg),
    .cpkt_vld(cpkt_vld), .cpkt_rdy(cpkt_rdy), .cpkt_dat(cpkt_dat), .cpkt_msg(cpkt_msg),
    .cpkt_ncell(cpkt_ncell),
`ifdef CPKT_UNF_MC_STAT_EN
    .stat_pkt(stat_pkt), .stat_err(stat_err),
`endif
    .err_pls(err_pls)
  );
  always #5 clk = ~clk;
  int n_tst = 0, n_fail = 0;
  logic [DW-1:0] cur[$];
  bit in_pkt = 0, drp = 0, m_vld = 0;
  logic [DW-1:0] m_slot[MC];
  logic [MW-1:0] m_msg = '0;
  int m_ncell = 0, m_spk = 0, m_ser = 0;
  logic [3:0] m_err = '0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tst++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input bit v, input bit s, input bit e, input bit r, input bit rs = 1'b0);
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    logic [3:0] ne;
    bit done;
    for (int k = 0; k < DW/32; k++) d[32*k +: 32] = $urandom;
    m = MW'({$urandom, $urandom});
    m[3] = s;
    m[2] = e;
    rst = rs; cell_vld = v; cell_dat = d; cell_msg = m; cpkt_rdy = r;
    if (rs) begin
      cur.delete(); in_pkt = 0; drp = 0; m_vld = 0; m_msg = '0; m_ncell = 0;
      m_err = '0; m_spk = 0; m_ser = 0;
      for (int i = 0; i < MC; i++) m_slot[i] = '0;
    end else begin
      if (m_err != 0) m_ser++;
      if (m_vld && r) m_spk++;
      ne = '0;
      done = 0;
      if (v) begin
        if (s) begin
          if (in_pkt) ne[1] = 1;
          cur.delete(); cur.push_back(d); in_pkt = 1; drp = 0;
        end else if (in_pkt) cur.push_back(d);
        else if (drp) begin
          if (e) drp = 0;
        end else ne[0] = 1;
        if (in_pkt && e) begin done = 1; in_pkt = 0; end
        else if (in_pkt && cur.size() == MC) begin ne[2] = 1; in_pkt = 0; drp = 1; end
      end
      if (done) begin
        if (m_vld && !r) ne[3] = 1;
        else begin
          m_vld = 1; m_msg = m; m_ncell = cur.size();
          for (int i = 0; i < MC; i++) m_slot[i] = i < cur.size() ? cur[i] : '0;
        end
      end else if (m_vld && r) m_vld = 0;
      m_err = ne;
    end
    @(negedge clk);
    chk("vld", DW'(cpkt_vld), DW'(m_vld));
    chk("err", DW'(err_pls), DW'(m_err));
    chk("ncell", DW'(cpkt_ncell), DW'(m_ncell));
    chk("msg", DW'(cpkt_msg), DW'(m_msg));
    for (int i = 0; i < MC; i++) chk($sformatf("dat%0d", i), cpkt_dat[DW*(MC-1-i) +: DW], m_slot[i]);
`ifdef CPKT_UNF_MC_STAT_EN
    chk("stat_pkt", DW'(stat_pkt), DW'(m_spk));
    chk("stat_err", DW'(stat_err), DW'(m_ser));
`endif
  endtask
  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 1, 1);
    cyc(1, 1, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 1); cyc(1, 1, 0, 1);
    repeat (6) cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1); cyc(1, 1, 0, 1); cyc(1, 0, 0, 1); cyc(1, 1, 0, 1); cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 1);
    repeat (8) cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1); cyc(1, 1, 0, 1); cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(0, 0, 0, 0); cyc(1, 1, 1, 1); cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 1);
    repeat (3) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1, 1); cyc(1, 1, 0, 1); cyc(1, 0, 1, 1); cyc(0, 0, 0, 1);
    repeat (3000)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tst, n_fail);
    $finish;
  end
endmodule
